// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master sequencer: mode encoding, FSM states
// and the transaction width.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    // Mode encoding driven by the CPU on control_rd.
    localparam logic [1:0] SPI_MODE_WRITE = 2'b00;
    localparam logic [1:0] SPI_MODE_EXCH  = 2'b01;
    localparam logic [1:0] SPI_MODE_READ  = 2'b10;
    localparam logic [1:0] SPI_MODE_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_e;

    // A start request is only honoured for the three defined modes.
    function automatic logic is_valid_mode(input logic [1:0] mode);
        return mode != SPI_MODE_RSVD;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for SCLK generation. Emits a rise strobe and a fall
// strobe alternately, one every CLK_DIV cycles, starting with a rise strobe
// after a synchronous clear. Strobes are suppressed while clr is asserted.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int              CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;  // 0: next strobe is a rise, 1: next is a fall
    logic             tick;

    // Count half periods; toggle the phase at the end of each one.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign tick     = (cnt == LAST) && !clr;
    assign rise_stb = tick && !phase;
    assign fall_stb = tick &&  phase;

endmodule

// File: rtl/spi_master_seq.sv
// Byte-level SPI master sequencer, mode 0 (CPOL=0, CPHA=0), MSB first.
// One start strobe runs a full 8-bit transaction: chip select, SCLK
// generation, MOSI shifting, MISO capture, and done/dv_data_out pulses.
//
// Build option: define SPI_LOOPBACK_EN to feed the registered mosi back into
// the receive shifter instead of the miso pin.
//
// Timeline with N = CLK_DIV, cycle 0 = acceptance edge:
//   1        cs_n falls, busy rises, first MOSI bit driven
//   N+1      first SCLK rise (bit 7 sampled)
//   2N+1+2Nk SCLK falls, MOSI advances (not after bit 0)
//   17N+1    end of the last SCLK low half, enter HOLD
//   18N+1    done / dv_data_out / cs_n high
module spi_master_seq
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        control_rd,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              dv_data_out,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    spi_state_e        state;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [2:0]        bit_cnt;
    logic              shift_end;  // set after the 8th falling edge
    logic              div_clr;
    logic              rise_stb;
    logic              fall_stb;
    logic              rx_bit;

    // The divider is held in clear while idle and during the first SETUP
    // cycle (cs_n still high), so the first rise strobe lands N cycles after
    // cs_n falls.
    assign div_clr = (state == IDLE) || (state == SETUP && cs_n);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .reset    (reset),
        .clr      (div_clr),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

`ifdef SPI_LOOPBACK_EN
    // miso stays connected but is masked out; the shifter sees our own mosi.
    assign rx_bit = mosi ^ (miso & 1'b0);
`else
    assign rx_bit = miso;
`endif

    // Transaction FSM with all pin-level outputs registered.
    // NOTE: every state and output register here uses non-blocking
    // assignment so all of them update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= SPI_MODE_WRITE;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= 3'd0;
            shift_end   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dv_data_out <= 1'b0;
            data_out    <= '0;
            sclk        <= 1'b0;
            cs_n        <= 1'b1;
            mosi        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_valid_mode(control_rd)) begin
                        state     <= SETUP;
                        mode_q    <= control_rd;
                        // Read mode transmits zeros, so mosi stays low.
                        tx_sr     <= (control_rd == SPI_MODE_READ) ? '0 : data_in;
                        rx_sr     <= '0;
                        bit_cnt   <= 3'd0;
                        shift_end <= 1'b0;
                    end
                end

                SETUP: begin
                    if (cs_n) begin
                        cs_n <= 1'b0;
                        busy <= 1'b1;
                        mosi <= tx_sr[DATA_W-1];
                    end
                    if (rise_stb) begin
                        state <= SHIFT;
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
                    end
                end

                SHIFT: begin
                    if (rise_stb) begin
                        if (shift_end) begin
                            // Last low half-period finished: no 9th pulse.
                            state     <= HOLD;
                            bit_cnt   <= 3'd0;
                            shift_end <= 1'b0;
                        end else begin
                            sclk  <= 1'b1;
                            rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
                        end
                    end else if (fall_stb) begin
                        sclk <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            shift_end <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_sr   <= tx_sr << 1;
                            mosi    <= tx_sr[DATA_W-2];
                        end
                    end
                end

                HOLD: begin
                    if (fall_stb) begin
                        state <= DONE;
                        cs_n  <= 1'b1;
                        mosi  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (mode_q != SPI_MODE_WRITE) begin
                            data_out    <= rx_sr;
                            dv_data_out <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // A start seen in this cycle is dropped; IDLE takes the next.
                    state       <= IDLE;
                    done        <= 1'b0;
                    dv_data_out <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_seq.sv
// Randomised scoreboard bench for spi_master_seq. A mode-0 slave model drives
// miso and collects mosi; the driver pushes expected completions, and a
// monitor pops and compares on every done pulse. A second instance with
// CLK_DIV=1 checks the short-latency case.
module tb_spi_master_seq;
    import spi_pkg::*;

    localparam int N  = 2;
    localparam int N1 = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] control_rd;
    logic [7:0] data_in;
    logic       busy, done, dv_data_out, sclk, cs_n, mosi, miso;
    logic [7:0] data_out;

    logic       start1;
    logic       busy1, done1, dv1, sclk1, cs_n1, mosi1;
    logic [7:0] data_out1;
    logic       miso1 = 1'b1;

    always #5 clk = ~clk;

    spi_master_seq #(.CLK_DIV(N)) u_dut (
        .clk(clk), .reset(reset), .start(start), .control_rd(control_rd),
        .data_in(data_in), .busy(busy), .done(done), .data_out(data_out),
        .dv_data_out(dv_data_out), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso)
    );

    spi_master_seq #(.CLK_DIV(N1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .control_rd(SPI_MODE_EXCH),
        .data_in(8'h3C), .busy(busy1), .done(done1), .data_out(data_out1),
        .dv_data_out(dv1), .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1),
        .miso(miso1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- slave model (mode 0) ----------------
    logic [7:0] slave_tx = 8'h00;
    logic [7:0] slave_sr = 8'h00;
    logic [7:0] slave_rx = 8'h00;
    int         slave_nbits = 0;

    initial miso = 1'b0;
    always @(negedge cs_n) begin
        slave_sr    = slave_tx;
        slave_rx    = 8'h00;
        slave_nbits = 0;
        miso        = slave_sr[7];
    end
    always @(posedge sclk) begin
        slave_rx = {slave_rx[6:0], mosi};
        slave_nbits++;
    end
    always @(negedge sclk) begin
        slave_sr = slave_sr << 1;
        miso     = slave_sr[7];
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int         cyc;
        logic       dv;
        logic [7:0] dout;
        logic [7:0] tx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_dout = 8'h00;

    function automatic logic [7:0] model_rx(input logic [1:0] mode, input logic [7:0] din,
                                            input logic [7:0] sbyte);
`ifdef SPI_LOOPBACK_EN
        return (mode == SPI_MODE_EXCH) ? din : 8'h00;
`else
        return sbyte;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding transaction.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("dv_data_out", dv_data_out, e.dv);
                check("data_out", data_out, e.dout);
                check("busy_at_done", busy, 1'b0);
                check("cs_n_at_done", cs_n, 1'b1);
                check("slave_rx_bits", slave_nbits, 8);
                check("slave_rx_byte", slave_rx, e.tx);
            end
        end
    end

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Issue one transaction; extra_at > 0 pulses a second start that the DUT
    // must ignore, sampled extra_at cycles after acceptance.
    task automatic run_txn(input logic [1:0] mode, input logic [7:0] din,
                           input logic [7:0] sbyte, input int extra_at);
        exp_t e;
        int   acc;
        @(negedge clk);
        slave_tx   = sbyte;
        start      = 1'b1;
        control_rd = mode;
        data_in    = din;
        acc        = cyc + 1;
        if (mode != SPI_MODE_WRITE) model_dout = model_rx(mode, din, sbyte);
        e.cyc  = acc + 18 * N + 1;
        e.dv   = (mode != SPI_MODE_WRITE);
        e.dout = model_dout;
        e.tx   = (mode == SPI_MODE_READ) ? 8'h00 : din;
        exp_q.push_back(e);
        @(negedge clk);
        start      = 1'b0;
        control_rd = 2'($urandom);
        data_in    = 8'($urandom);
        if (extra_at > 0) begin
            while (cyc < acc + extra_at - 1) @(negedge clk);
            start      = 1'b1;
            control_rd = SPI_MODE_EXCH;
            @(negedge clk);
            start      = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int         acc;
        int         got_cyc;
        logic [7:0] got_dout;
        logic       got_dv;

        reset      = 1'b1;
        start      = 1'b0;
        start1     = 1'b0;
        control_rd = SPI_MODE_WRITE;
        data_in    = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dv", dv_data_out, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        reset = 1'b0;

        // Directed cases
        run_txn(SPI_MODE_WRITE, 8'hA5, 8'h77, 0);
        run_txn(SPI_MODE_READ,  8'hFF, 8'h0F, 0);
        run_txn(SPI_MODE_EXCH,  8'h3C, 8'hC3, 0);
        run_txn(SPI_MODE_EXCH,  8'h5A, 8'hFF, 0);
        run_txn(SPI_MODE_WRITE, 8'h12, 8'h34, 5);

        // Reserved-mode start while idle: nothing may happen
        @(negedge clk);
        start      = 1'b1;
        control_rd = SPI_MODE_RSVD;
        data_in    = 8'hE7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rsvd_cs_n", cs_n, 1'b1);
        check("rsvd_busy", busy, 1'b0);
        repeat (40) @(negedge clk);
        check("rsvd_data_out", data_out, model_dout);

        // Randomised transactions
        for (int i = 0; i < 20; i++) begin
            run_txn(2'($urandom_range(2, 0)), 8'($urandom), 8'($urandom), 0);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        // Make sure data_out is non-zero before the mid-transaction reset
        run_txn(SPI_MODE_EXCH, 8'h81, 8'h96, 0);

        // Reset at cycle 10 of a read
        @(negedge clk);
        slave_tx   = 8'h6D;
        start      = 1'b1;
        control_rd = SPI_MODE_READ;
        data_in    = 8'($urandom);
        acc        = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + 9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cs_n", cs_n, 1'b1);
        check("midrst_sclk", sclk, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_mosi", mosi, 1'b0);
        check("midrst_data_out", data_out, 8'h00);
        model_dout = 8'h00;
        reset = 1'b0;
        repeat (45) @(negedge clk);
        check("midrst_no_done_data", data_out, 8'h00);
        check("midrst_idle_cs_n", cs_n, 1'b1);

        // CLK_DIV = 1 exchange: 8'h3C out, miso held high
        @(negedge clk);
        start1  = 1'b1;
        acc     = cyc + 1;
        got_cyc = -1;
        got_dout = 8'h00;
        got_dv   = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done1 && got_cyc < 0) begin
                got_cyc  = cyc;
                got_dout = data_out1;
                got_dv   = dv1;
            end
            @(negedge clk);
        end
        check("div1_done_cycle", got_cyc, acc + 18 * N1 + 1);
        check("div1_dv", got_dv, 1'b1);
        check("div1_data_out", got_dout, model_rx(SPI_MODE_EXCH, 8'h3C, 8'hFF));
        check("div1_cs_n_idle", cs_n1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
